// File: rtl/multi_mode_flop_bank.sv
// Bank of NUM_CH WIDTH-bit registers updated one channel per command in D/JK/T/SR mode,
// with per-channel change pulse, saturating change counter and sticky error flags.
module mmfb_chan #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             we,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic             changed,
  output logic [CNT_W-1:0] cnt
);
  logic [WIDTH-1:0] nxt;
  logic             diff;

  always_comb begin
    nxt = q;
    case (mode)
      2'b00:   nxt = a;
      2'b01:   nxt = (a & ~q) | (~b & q);
      2'b10:   nxt = q ^ a;
      default: nxt = (q & ~b) | (a & ~b) | (q & a & b);
    endcase
  end

  assign diff = we && (nxt != q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q       <= RESET_VAL;
      changed <= 1'b0;
      cnt     <= '0;
    end else if (clr) begin
      q       <= RESET_VAL;
      changed <= 1'b0;
      cnt     <= '0;
    end else begin
      changed <= diff;
      if (diff) begin
        q <= nxt;
        // counter sticks at all-ones rather than wrapping
        if (cnt != '1) cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module multi_mode_flop_bank #(
  parameter int WIDTH = 32,
  parameter int NUM_CH = 4,
  parameter int CNT_W = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SW-1:0]           ch_sel,
  input  logic [1:0]              mode,
  input  logic [WIDTH-1:0]        a,
  input  logic [WIDTH-1:0]        b,
  output logic [NUM_CH*WIDTH-1:0] q,
  output logic [NUM_CH-1:0]       changed,
  output logic [NUM_CH*CNT_W-1:0] chg_cnt,
  output logic                    sel_err,
  output logic                    sr_err
);
  logic acc, sel_ok;

  assign in_ready = ~clr;
  assign acc      = in_valid & in_ready;
  assign sel_ok   = (32'(ch_sel) < NUM_CH);

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    mmfb_chan #(.WIDTH(WIDTH), .CNT_W(CNT_W), .RESET_VAL(RESET_VAL)) u_ch (
      .clk(clk), .reset(reset), .clr(clr),
      .we(acc && (ch_sel == SW'(n))),
      .mode(mode), .a(a), .b(b),
      .q(q[n*WIDTH +: WIDTH]),
      .changed(changed[n]),
      .cnt(chg_cnt[n*CNT_W +: CNT_W])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_err <= 1'b0;
      sr_err  <= 1'b0;
    end else if (clr) begin
      sel_err <= 1'b0;
      sr_err  <= 1'b0;
    end else begin
      if (acc && !sel_ok) sel_err <= 1'b1;
      if (acc && (mode == 2'b11) && |(a & b)) sr_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_multi_mode_flop_bank.sv
// Bench for multi_mode_flop_bank: 4-channel/CNT_W=2 instance driven from a vector table
// through a scoreboard queue, plus a 3-channel instance for out-of-range select and async reset.
module tb_multi_mode_flop_bank;
  logic clk = 0;
  always #5 clk = ~clk;

  logic         reset, clr, in_valid, in_ready;
  logic [1:0]   ch_sel, mode;
  logic [31:0]  a, b;
  logic [127:0] q;
  logic [3:0]   changed;
  logic [7:0]   chg_cnt;
  logic         sel_err, sr_err;

  multi_mode_flop_bank #(.WIDTH(32), .NUM_CH(4), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .ch_sel(ch_sel), .mode(mode), .a(a), .b(b), .q(q), .changed(changed),
    .chg_cnt(chg_cnt), .sel_err(sel_err), .sr_err(sr_err));

  logic        clr1, in_valid1, in_ready1;
  logic [1:0]  ch_sel1, mode1;
  logic [7:0]  a1, b1;
  logic [23:0] q1, chg_cnt1;
  logic [2:0]  changed1;
  logic        sel_err1, sr_err1;

  multi_mode_flop_bank #(.WIDTH(8), .NUM_CH(3), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .clr(clr1), .in_valid(in_valid1), .in_ready(in_ready1),
    .ch_sel(ch_sel1), .mode(mode1), .a(a1), .b(b1), .q(q1), .changed(changed1),
    .chg_cnt(chg_cnt1), .sel_err(sel_err1), .sr_err(sr_err1));

  localparam logic [1:0] MD = 2'b00, MJK = 2'b01, MT = 2'b10, MSR = 2'b11;

  typedef struct {
    logic [1:0]  ch;
    logic [1:0]  mode;
    logic [31:0] a, b;
    logic [31:0] eq;
    logic        chg;
    logic [1:0]  cnt;
    logic        sr;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];
  vec_t sb[$];
  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_chk(input int idx);
    vec_t e;
    logic [3:0] ec;
    e  = sb.pop_front();
    ec = 4'(e.chg) << e.ch;
    chk($sformatf("v%0d q", idx), 128'(q[e.ch*32 +: 32]), 128'(e.eq));
    chk($sformatf("v%0d changed", idx), 128'(changed), 128'(ec));
    chk($sformatf("v%0d cnt", idx), 128'(chg_cnt[e.ch*2 +: 2]), 128'(e.cnt));
    chk($sformatf("v%0d sr_err", idx), 128'(sr_err), 128'(e.sr));
  endtask

  initial begin
    vecs[0]  = '{2'd2, MD,  32'hA5A5_0000, 32'h0,         32'hA5A5_0000, 1'b1, 2'd1, 1'b0};
    vecs[1]  = '{2'd2, MT,  32'hFFFF_FFFF, 32'h0,         32'h5A5A_FFFF, 1'b1, 2'd2, 1'b0};
    vecs[2]  = '{2'd0, MD,  32'h0000_00F0, 32'h0,         32'h0000_00F0, 1'b1, 2'd1, 1'b0};
    vecs[3]  = '{2'd0, MJK, 32'h0000_00CC, 32'h0000_00AA, 32'h0000_005C, 1'b1, 2'd2, 1'b0};
    vecs[4]  = '{2'd1, MD,  32'h0000_000F, 32'h0,         32'h0000_000F, 1'b1, 2'd1, 1'b0};
    vecs[5]  = '{2'd1, MSR, 32'h0000_0033, 32'h0000_0055, 32'h0000_002B, 1'b1, 2'd2, 1'b1};
    vecs[6]  = '{2'd1, MD,  32'h0000_002B, 32'h0,         32'h0000_002B, 1'b0, 2'd2, 1'b1};
    vecs[7]  = '{2'd0, MT,  32'h0,         32'h0,         32'h0000_005C, 1'b0, 2'd2, 1'b1};
    vecs[8]  = '{2'd3, MD,  32'h1,         32'h0,         32'h1,         1'b1, 2'd1, 1'b1};
    vecs[9]  = '{2'd3, MD,  32'h2,         32'h0,         32'h2,         1'b1, 2'd2, 1'b1};
    vecs[10] = '{2'd3, MD,  32'h3,         32'h0,         32'h3,         1'b1, 2'd3, 1'b1};
    vecs[11] = '{2'd3, MD,  32'h4,         32'h0,         32'h4,         1'b1, 2'd3, 1'b1};
    vecs[12] = '{2'd3, MD,  32'h5,         32'h0,         32'h5,         1'b1, 2'd3, 1'b1};
    vecs[13] = '{2'd2, MJK, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hA5A5_0000, 1'b1, 2'd3, 1'b1};

    reset = 0; clr = 0; in_valid = 0; ch_sel = 0; mode = 0; a = 0; b = 0;
    clr1 = 0; in_valid1 = 0; ch_sel1 = 0; mode1 = 0; a1 = 0; b1 = 0;
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("rst q", q, 128'h0);
    chk("rst cnt", 128'(chg_cnt), 128'h0);
    chk("rst changed", 128'(changed), 128'h0);
    chk("rst errs", 128'({sel_err, sr_err}), 128'h0);
    chk("rst in_ready", 128'(in_ready), 128'h1);

    // back-to-back commands, one per cycle; each result is checked one cycle after drive
    for (int i = 0; i < NV; i++) begin
      if (i > 0) pop_chk(i - 1);
      in_valid = 1; ch_sel = vecs[i].ch; mode = vecs[i].mode; a = vecs[i].a; b = vecs[i].b;
      sb.push_back(vecs[i]);
      @(negedge clk);
    end
    in_valid = 0;
    pop_chk(NV - 1);
    @(negedge clk);
    chk("idle changed", 128'(changed), 128'h0);
    chk("full q", q, {32'h5, 32'hA5A5_0000, 32'h2B, 32'h5C});
    chk("full cnt", 128'(chg_cnt), 128'hFA);
    chk("sr sticky", 128'(sr_err), 128'h1);

    // clear with a coincident command: command must not be taken
    clr = 1; in_valid = 1; ch_sel = 0; mode = MD; a = 32'hDEAD_BEEF;
    #1 chk("clr in_ready", 128'(in_ready), 128'h0);
    @(negedge clk);
    clr = 0; in_valid = 0;
    chk("clr q", q, 128'h0);
    chk("clr cnt", 128'(chg_cnt), 128'h0);
    chk("clr changed", 128'(changed), 128'h0);
    chk("clr errs", 128'({sel_err, sr_err}), 128'h0);
    @(negedge clk);
    chk("post clr q", q, 128'h0);
    chk("post clr changed", 128'(changed), 128'h0);

    // 3-channel instance: valid write, then out-of-range select
    in_valid1 = 1; ch_sel1 = 2'd0; mode1 = MD; a1 = 8'h11;
    @(negedge clk);
    chk("c3 q", 128'(q1), 128'h11);
    ch_sel1 = 2'd3; a1 = 8'hFF;
    @(negedge clk);
    in_valid1 = 0;
    chk("c3 bad q", 128'(q1), 128'h11);
    chk("c3 bad changed", 128'(changed1), 128'h0);
    chk("c3 bad cnt", 128'(chg_cnt1), 128'h1);
    chk("c3 sel_err", 128'(sel_err1), 128'h1);
    @(negedge clk);
    chk("c3 sel_err sticky", 128'(sel_err1), 128'h1);
    // async reset between clock edges
    #2 reset = 0;
    #1;
    chk("async sel_err", 128'(sel_err1), 128'h0);
    chk("async q1", 128'(q1), 128'h0);
    chk("async cnt1", 128'(chg_cnt1), 128'h0);
    @(negedge clk);
    chk("rst hold q1", 128'(q1), 128'h0);
    reset = 1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
